// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: ordered-set type encodings, per-type cycle
// costs and the transmit scheduler state encoding.
package pcie_phy_pkg;

  // One-hot ordered-set type codes as presented by the LTSSM.
  localparam logic [4:0] OS_TS1   = 5'b10000;
  localparam logic [4:0] OS_TS2   = 5'b01000;
  localparam logic [4:0] OS_EIOS  = 5'b00100;
  localparam logic [4:0] OS_EIEOS = 5'b00010;
  localparam logic [4:0] OS_FTS   = 5'b00001;

  // Framer cycles consumed per ordered set of each type.
  localparam int unsigned P_TS1   = 4;
  localparam int unsigned P_TS2   = 4;
  localparam int unsigned P_EIOS  = 1;
  localparam int unsigned P_EIEOS = 4;
  localparam int unsigned P_FTS   = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OS_LOAD = 3'd1,
    OS_RUN  = 3'd2,
    PKT_RUN = 3'd3,
    PKT_END = 3'd4,
    GAP     = 3'd5
  } sched_state_t;

  // Cycles per ordered set; 0 flags an encoding that is not a legal one-hot type.
  function automatic int unsigned os_period(input logic [4:0] os_type);
    case (os_type)
      OS_TS1:   return P_TS1;
      OS_TS2:   return P_TS2;
      OS_EIOS:  return P_EIOS;
      OS_EIEOS: return P_EIEOS;
      OS_FTS:   return P_FTS;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/tx_link_scheduler.sv
// Transmit-side scheduler: arbitrates LTSSM ordered-set bursts against DLL
// packets, one operation at a time with the LTSSM favoured at each boundary,
// and drives the frame generator's control inputs from registered outputs.
module tx_link_scheduler
  import pcie_phy_pkg::*;
#(
  parameter int LEN_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_up,
  input  logic             os_req,
  input  logic [4:0]       os_type,
  input  logic [39:0]      os_data,
  input  logic [CNT_W-1:0] os_count,
  output logic             os_ack,
  output logic             os_busy,
  input  logic             pkt_req,
  input  logic             pkt_is_dllp,
  input  logic             pkt_nullify,
  input  logic [LEN_W-1:0] pkt_len,
  output logic             pkt_gnt,
  output logic             pkt_rd,
  output logic [63:0]      fg_ltssm_word,
  output logic             fg_tlp_sent,
  output logic             fg_dllp_sent,
  output logic             fg_null_sent,
  output logic             fg_framer_en,
  output logic             sched_err
);

  localparam logic [CNT_W+1:0] OS_ONE  = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  sched_state_t     state;
  logic [CNT_W+1:0] os_cnt;
  logic [LEN_W-1:0] len_cnt;
  logic             os_err_q;
  logic             pkt_null_q;

  logic             os_type_ok;
  logic             os_long;
  logic [CNT_W+1:0] os_budget;
  logic [15:0]      os_count16;
  logic             pkt_bad;

  // A four-cycle ordered set turns the repeat count into a budget by a 2-bit shift.
  assign os_type_ok = (os_period(os_type) != 0);
  assign os_long    = (os_period(os_type) == 4);
  assign os_budget  = os_long ? {os_count, 2'b00} : {2'b00, os_count};
  assign os_count16 = 16'(os_count);
  assign pkt_bad    = (pkt_is_dllp & pkt_nullify) | (pkt_len == '0);

  // Scheduler FSM; every output is registered and describes the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      os_cnt        <= '0;
      len_cnt       <= '0;
      os_err_q      <= 1'b0;
      pkt_null_q    <= 1'b0;
      os_ack        <= 1'b0;
      os_busy       <= 1'b0;
      pkt_gnt       <= 1'b0;
      pkt_rd        <= 1'b0;
      fg_ltssm_word <= '0;
      fg_tlp_sent   <= 1'b0;
      fg_dllp_sent  <= 1'b0;
      fg_null_sent  <= 1'b0;
      fg_framer_en  <= 1'b0;
      sched_err     <= 1'b0;
    end else begin
      os_ack  <= 1'b0;
      pkt_gnt <= 1'b0;
      if (os_req && !os_type_ok) begin
        sched_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (os_req) begin
            state         <= OS_LOAD;
            os_ack        <= 1'b1;
            os_busy       <= 1'b1;
            os_err_q      <= !os_type_ok;
            os_cnt        <= os_budget;
            fg_ltssm_word <= os_type_ok ? {os_data, os_type, 3'b000, os_count16} : '0;
          end else if (pkt_req && link_up) begin
            pkt_gnt    <= 1'b1;
            len_cnt    <= pkt_len;
            pkt_null_q <= pkt_nullify & ~pkt_is_dllp;
            if (pkt_bad) begin
              sched_err <= 1'b1;
              state     <= GAP;
            end else begin
              state        <= PKT_RUN;
              fg_framer_en <= 1'b1;
              fg_tlp_sent  <= ~pkt_is_dllp;
              fg_dllp_sent <= pkt_is_dllp;
              pkt_rd       <= 1'b1;
            end
          end
        end

        OS_LOAD: begin
          fg_ltssm_word <= '0;
          if (os_err_q || os_cnt == '0) begin
            state   <= GAP;
            os_busy <= 1'b0;
          end else begin
            state <= OS_RUN;
          end
        end

        OS_RUN: begin
          if (os_cnt <= OS_ONE) begin
            state   <= GAP;
            os_busy <= 1'b0;
            os_cnt  <= '0;
          end else begin
            os_cnt <= os_cnt - OS_ONE;
          end
        end

        PKT_RUN: begin
          if (len_cnt <= LEN_ONE) begin
            state        <= PKT_END;
            len_cnt      <= '0;
            fg_tlp_sent  <= 1'b0;
            fg_dllp_sent <= 1'b0;
            pkt_rd       <= 1'b0;
            fg_null_sent <= pkt_null_q;
          end else begin
            len_cnt <= len_cnt - LEN_ONE;
          end
        end

        PKT_END: begin
          state        <= GAP;
          fg_framer_en <= 1'b0;
          fg_null_sent <= 1'b0;
        end

        GAP: begin
          state         <= IDLE;
          os_busy       <= 1'b0;
          pkt_rd        <= 1'b0;
          fg_ltssm_word <= '0;
          fg_tlp_sent   <= 1'b0;
          fg_dllp_sent  <= 1'b0;
          fg_null_sent  <= 1'b0;
          fg_framer_en  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Bench for tx_link_scheduler: a transaction-level model expands each
// accepted request into its expected per-cycle output timeline, a negedge
// process compares the DUT against it every cycle, and directed scenarios
// pin key values with hand-computed literals.
module tb_tx_link_scheduler;

  localparam int LEN_W = 10;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             link_up = 1'b0;
  logic             os_req = 1'b0;
  logic [4:0]       os_type = '0;
  logic [39:0]      os_data = '0;
  logic [CNT_W-1:0] os_count = '0;
  logic             pkt_req = 1'b0;
  logic             pkt_is_dllp = 1'b0;
  logic             pkt_nullify = 1'b0;
  logic [LEN_W-1:0] pkt_len = '0;

  logic        os_ack, os_busy, pkt_gnt, pkt_rd;
  logic [63:0] fg_ltssm_word;
  logic        fg_tlp_sent, fg_dllp_sent, fg_null_sent, fg_framer_en, sched_err;

  tx_link_scheduler #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .link_up(link_up),
    .os_req(os_req), .os_type(os_type), .os_data(os_data), .os_count(os_count),
    .os_ack(os_ack), .os_busy(os_busy),
    .pkt_req(pkt_req), .pkt_is_dllp(pkt_is_dllp), .pkt_nullify(pkt_nullify),
    .pkt_len(pkt_len), .pkt_gnt(pkt_gnt), .pkt_rd(pkt_rd),
    .fg_ltssm_word(fg_ltssm_word), .fg_tlp_sent(fg_tlp_sent),
    .fg_dllp_sent(fg_dllp_sent), .fg_null_sent(fg_null_sent),
    .fg_framer_en(fg_framer_en), .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        busy;
    logic        gnt;
    logic        rd;
    logic [63:0] word;
    logic        tlp;
    logic        dllp;
    logic        nul;
    logic        en;
  } obs_t;

  obs_t exp_q[$];
  bit   model_err = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic obs_t sampleDut();
    obs_t o;
    o.ack  = os_ack;
    o.busy = os_busy;
    o.gnt  = pkt_gnt;
    o.rd   = pkt_rd;
    o.word = fg_ltssm_word;
    o.tlp  = fg_tlp_sent;
    o.dllp = fg_dllp_sent;
    o.nul  = fg_null_sent;
    o.en   = fg_framer_en;
    return o;
  endfunction

  // Expand the request that wins arbitration this cycle into the outputs
  // expected on each following cycle, straight from the scheduling rules.
  task automatic arbitrate();
    obs_t r;
    bit   ok;
    int   per;
    if (os_req) begin
      ok  = ($countones(os_type) == 1);
      per = (os_type == 5'b00100 || os_type == 5'b00001) ? 1 : 4;
      r = '0; r.ack = 1'b1; r.busy = 1'b1;
      if (ok) r.word = {os_data, os_type, 3'b000, os_count};
      exp_q.push_back(r);
      if (ok) begin
        for (int i = 0; i < int'(os_count) * per; i++) begin
          r = '0; r.busy = 1'b1;
          exp_q.push_back(r);
        end
      end
      r = '0;
      exp_q.push_back(r);
    end else if (pkt_req && link_up) begin
      if ((pkt_is_dllp && pkt_nullify) || pkt_len == 0) begin
        model_err = 1'b1;
        r = '0; r.gnt = 1'b1;
        exp_q.push_back(r);
      end else begin
        for (int i = 0; i < int'(pkt_len); i++) begin
          r = '0; r.gnt = (i == 0); r.rd = 1'b1; r.en = 1'b1;
          r.tlp = !pkt_is_dllp; r.dllp = pkt_is_dllp;
          exp_q.push_back(r);
        end
        r = '0; r.en = 1'b1; r.nul = pkt_nullify;
        exp_q.push_back(r);
        r = '0;
        exp_q.push_back(r);
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model timeline.
  initial begin
    obs_t exp_o;
    bit   idle_cycle;
    forever begin
      @(negedge clk);
      idle_cycle = 1'b0;
      if (!rst) begin
        exp_q.delete();
        model_err = 1'b0;
        exp_o = '0;
      end else if (exp_q.size() > 0) begin
        exp_o = exp_q.pop_front();
      end else begin
        exp_o = '0;
        idle_cycle = 1'b1;
      end
      checkOutput("cycle_outputs", sampleDut(), exp_o);
      checkOutput("sched_err", 72'(sched_err), 72'(model_err));
      if (rst) begin
        if (os_req && $countones(os_type) != 1) model_err = 1'b1;
        if (idle_cycle) arbitrate();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitAck();
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (os_ack) break;
    end
    checkOutput("os_ack_seen", 72'(os_ack), 72'(1));
  endtask

  task automatic waitGnt();
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (pkt_gnt) break;
    end
    checkOutput("pkt_gnt_seen", 72'(pkt_gnt), 72'(1));
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick(2);
    checkOutput("reset_err_clear", 72'(sched_err), 72'(0));
    rst = 1'b1;
    tick(1);
  endtask

  // Directed scenarios with literal expectations alongside the model.
  task automatic applyStimulus();
    int n;
    bit gseen;

    tick(2);
    checkOutput("reset_outputs", sampleDut(), 72'(0));
    checkOutput("reset_err", 72'(sched_err), 72'(0));
    rst = 1'b1;
    tick(2);

    // TS1 burst of 3: load word, then 12 run cycles.
    os_type = 5'b10000; os_data = 40'h123456789A; os_count = 3; os_req = 1'b1;
    waitAck();
    os_req = 1'b0; os_data = '0; os_count = 99;
    checkOutput("ts1_load_word", 72'(fg_ltssm_word), 72'(64'h123456789A800003));
    checkOutput("ts1_type_field", 72'(fg_ltssm_word[23:19]), 72'(5'b10000));
    n = 1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (!os_busy) break;
      n++;
    end
    checkOutput("ts1_busy_cycles", 72'(n), 72'(13));
    tick(3);

    // TLP of 4 dwords; length changed after grant must be ignored.
    link_up = 1'b1; pkt_is_dllp = 1'b0; pkt_nullify = 1'b0; pkt_len = 4; pkt_req = 1'b1;
    waitGnt();
    pkt_req = 1'b0; pkt_len = 7;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (!fg_tlp_sent) break;
      n++;
    end
    checkOutput("tlp_sent_cycles", 72'(n), 72'(4));
    checkOutput("tlp_end_null", 72'(fg_null_sent), 72'(0));
    checkOutput("tlp_end_en", 72'(fg_framer_en), 72'(1));
    tick(3);

    // Nullified TLP of 2 dwords.
    pkt_nullify = 1'b1; pkt_len = 2; pkt_req = 1'b1;
    waitGnt();
    pkt_req = 1'b0; pkt_nullify = 1'b0;
    tick(2);
    checkOutput("null_end_flag", 72'(fg_null_sent), 72'(1));
    tick(3);

    // Simultaneous FTS x2 and DLLP len 2: ordered sets first.
    os_type = 5'b00001; os_count = 2; os_data = 40'hA5A5A5A5A5;
    pkt_is_dllp = 1'b1; pkt_len = 2; pkt_req = 1'b1; os_req = 1'b1;
    waitAck();
    os_req = 1'b0;
    checkOutput("prio_no_gnt_at_ack", 72'(pkt_gnt), 72'(0));
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      n++;
      if (pkt_gnt) break;
    end
    checkOutput("prio_gnt_delay", 72'(n), 72'(5));
    pkt_req = 1'b0; pkt_is_dllp = 1'b0;
    tick(6);

    // Link gating, then link drop mid-packet.
    link_up = 1'b0; pkt_len = 3; pkt_req = 1'b1;
    gseen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (pkt_gnt) gseen = 1'b1;
    end
    checkOutput("gated_no_gnt", 72'(gseen), 72'(0));
    link_up = 1'b1;
    tick(1);
    checkOutput("link_up_gnt_latency", 72'(pkt_gnt), 72'(1));
    pkt_req = 1'b0;
    n = 1;
    tick(1);
    link_up = 1'b0; pkt_req = 1'b1;
    if (fg_tlp_sent) n++;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (!fg_tlp_sent) break;
      n++;
    end
    checkOutput("linkdrop_tlp_cycles", 72'(n), 72'(3));
    gseen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (pkt_gnt) gseen = 1'b1;
    end
    checkOutput("linkdown_pending_no_gnt", 72'(gseen), 72'(0));
    pkt_req = 1'b0;
    tick(2);

    // Error: nullified DLLP is granted then dropped.
    link_up = 1'b1; pkt_is_dllp = 1'b1; pkt_nullify = 1'b1; pkt_len = 3; pkt_req = 1'b1;
    waitGnt();
    pkt_req = 1'b0; pkt_is_dllp = 1'b0; pkt_nullify = 1'b0;
    checkOutput("err_dllp_null", 72'(sched_err), 72'(1));
    checkOutput("err_dllp_null_no_en", 72'(fg_framer_en), 72'(0));
    tick(4);
    doReset();

    // Error: zero-length TLP.
    pkt_len = 0; pkt_req = 1'b1;
    waitGnt();
    pkt_req = 1'b0; pkt_len = 1;
    checkOutput("err_len_zero", 72'(sched_err), 72'(1));
    tick(4);
    doReset();

    // Error: ordered-set type not one-hot.
    os_type = 5'b11000; os_count = 2; os_req = 1'b1;
    waitAck();
    os_req = 1'b0;
    checkOutput("err_os_type", 72'(sched_err), 72'(1));
    checkOutput("err_os_type_word", 72'(fg_ltssm_word), 72'(0));
    tick(4);
    doReset();

    // Asynchronous reset in cycle 5 of a TS2 x10 burst, then a fresh request.
    os_type = 5'b01000; os_count = 10; os_data = 40'h0102030405; os_req = 1'b1;
    waitAck();
    os_req = 1'b0;
    tick(4);
    checkOutput("ts2_busy_before_reset", 72'(os_busy), 72'(1));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_outputs", sampleDut(), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    os_type = 5'b00001; os_count = 1; os_data = '0; os_req = 1'b1;
    waitAck();
    os_req = 1'b0;
    checkOutput("post_reset_word", 72'(fg_ltssm_word), 72'(64'h0000000000080001));
    tick(5);
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
